// File: rtl/i2c_txn_arbiter_if.sv
// rtl/i2c_txn_arbiter_if.sv - requester and I2C master register-port signals of the transaction arbiter
interface i2c_txn_arbiter_if #(
  parameter int NREQ = 4
);
  // requester side
  logic [NREQ-1:0]      req_i;
  logic [NREQ-1:0]      rd_i;
  logic [7*NREQ-1:0]    dev_addr_i;
  logic [3*NREQ-1:0]    nby_i;
  logic [32*NREQ-1:0]   wdata_i;
  logic [NREQ-1:0]      gnt_o;
  logic [NREQ-1:0]      done_o;
  logic [31:0]          rdata_o;
  logic                 err_o;
  // I2C master register port
  logic                 m_write_o;
  logic [3:0]           m_be_o;
  logic [4:0]           m_addr_o;
  logic [31:0]          m_wdata_o;
  logic [31:0]          m_rdata_i;

  // the arbiter
  modport master (
    input  req_i, rd_i, dev_addr_i, nby_i, wdata_i, m_rdata_i,
    output gnt_o, done_o, rdata_o, err_o, m_write_o, m_be_o, m_addr_o, m_wdata_o
  );

  // requesters plus the I2C master register file
  modport slave (
    output req_i, rd_i, dev_addr_i, nby_i, wdata_i, m_rdata_i,
    input  gnt_o, done_o, rdata_o, err_o, m_write_o, m_be_o, m_addr_o, m_wdata_o
  );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// rtl/i2c_txn_arbiter.sv - round-robin transaction arbiter for a shared I2C master register port; optional watchdog under I2C_ARB_TIMEOUT_EN
module i2c_txn_arbiter #(
  parameter int NREQ        = 4,
  parameter int POLL_GAP    = 15,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  i2c_txn_arbiter_if.master  bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [4:0]  REG_NBY = 5'd0;
  localparam logic [4:0]  REG_ADR = 5'd4;
  localparam logic [4:0]  REG_RDR = 5'd8;
  localparam logic [4:0]  REG_TDR = 5'd12;
  localparam logic [4:0]  REG_CFG = 5'd16;
  localparam logic [31:0] CMD_WR  = 32'h1;
  localparam logic [31:0] CMD_RD  = 32'h4;

  typedef enum logic [3:0] {
    IDLE, ARB, W_NBY, W_ADR, W_TDR, W_CFG, WAIT,
    P_ADDR, P_CHK, R_ADDR, R_CAP, CLR, DONE
  } state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic            op_rd;
  logic [6:0]      op_dev;
  logic [31:0]     op_wdata;
  logic [15:0]     gap_cnt;

  logic [PW-1:0]   cand;
  logic [PW-1:0]   win_idx;
  logic            win_found;
  logic            cfg_done;
  logic            wd_expire;

  // the master only takes 1..4 bytes; 0 means a single byte
  function automatic logic [31:0] nby_value(input logic [2:0] n);
    if (n == 3'd0)      return 32'd1;
    else if (n > 3'd4)  return 32'd4;
    else                return {29'd0, n};
  endfunction

  // first requesting index at or after rr_ptr, wrapping
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = PW'((int'(rr_ptr) + i) % NREQ);
      if (!win_found && bus.req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign cfg_done = op_rd ? (bus.m_rdata_i[3:2] == 2'b11) : (bus.m_rdata_i[1:0] == 2'b11);

`ifdef I2C_ARB_TIMEOUT_EN
  logic [16:0] wd_cnt;
  logic        timed_out;

  assign wd_expire = ((state == WAIT) || (state == P_ADDR) || (state == P_CHK)) &&
                     (wd_cnt >= 17'(TIMEOUT_CYC));

  // watchdog: counts polling cycles since the start command, flags the abort to the owner
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_cnt    <= '0;
      timed_out <= 1'b0;
      bus.err_o <= 1'b0;
    end else begin
      if (state == W_CFG)
        wd_cnt <= '0;
      else if (((state == WAIT) || (state == P_ADDR) || (state == P_CHK)) && !wd_expire)
        wd_cnt <= wd_cnt + 17'd1;
      if (state == ARB)
        timed_out <= 1'b0;
      else if (wd_expire)
        timed_out <= 1'b1;
      bus.err_o <= (state == CLR) && timed_out;
    end
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign wd_expire = 1'b0;
  assign bus.err_o = 1'b0;
`endif

  // transaction sequencer; each state's bus access is set up on entry so outputs are registered
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      op_rd         <= 1'b0;
      op_dev        <= '0;
      op_wdata      <= '0;
      gap_cnt       <= '0;
      bus.gnt_o     <= '0;
      bus.done_o    <= '0;
      bus.rdata_o   <= '0;
      bus.m_write_o <= 1'b0;
      bus.m_be_o    <= 4'h0;
      bus.m_addr_o  <= REG_CFG;
      bus.m_wdata_o <= '0;
    end else begin
      bus.m_write_o <= 1'b0;
      bus.m_be_o    <= 4'h0;
      bus.done_o    <= '0;
      if (wd_expire) begin
        bus.rdata_o   <= '0;
        bus.m_write_o <= 1'b1;
        bus.m_be_o    <= 4'hF;
        bus.m_addr_o  <= REG_CFG;
        bus.m_wdata_o <= '0;
        state         <= CLR;
      end else begin
        case (state)
          IDLE: begin
            if (|bus.req_i) state <= ARB;
          end
          ARB: begin
            if (win_found) begin
              op_rd         <= bus.rd_i[win_idx];
              op_dev        <= bus.dev_addr_i[7*win_idx +: 7];
              op_wdata      <= bus.wdata_i[32*win_idx +: 32];
              bus.gnt_o     <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
              rr_ptr        <= (int'(win_idx) == NREQ-1) ? '0 : win_idx + 1'b1;
              bus.rdata_o   <= '0;
              bus.m_write_o <= 1'b1;
              bus.m_be_o    <= 4'hF;
              bus.m_addr_o  <= REG_NBY;
              bus.m_wdata_o <= nby_value(bus.nby_i[3*win_idx +: 3]);
              state         <= W_NBY;
            end else begin
              state <= IDLE;
            end
          end
          W_NBY: begin
            bus.m_write_o <= 1'b1;
            bus.m_be_o    <= 4'hF;
            bus.m_addr_o  <= REG_ADR;
            bus.m_wdata_o <= {25'd0, op_dev};
            state         <= W_ADR;
          end
          W_ADR: begin
            bus.m_write_o <= 1'b1;
            bus.m_be_o    <= 4'hF;
            if (op_rd) begin
              bus.m_addr_o  <= REG_CFG;
              bus.m_wdata_o <= CMD_RD;
              state         <= W_CFG;
            end else begin
              bus.m_addr_o  <= REG_TDR;
              bus.m_wdata_o <= op_wdata;
              state         <= W_TDR;
            end
          end
          W_TDR: begin
            bus.m_write_o <= 1'b1;
            bus.m_be_o    <= 4'hF;
            bus.m_addr_o  <= REG_CFG;
            bus.m_wdata_o <= CMD_WR;
            state         <= W_CFG;
          end
          W_CFG: begin
            gap_cnt <= '0;
            state   <= WAIT;
          end
          WAIT: begin
            if ({16'd0, gap_cnt} + 32'd1 >= 32'(POLL_GAP)) begin
              bus.m_addr_o <= REG_CFG;
              state        <= P_ADDR;
            end else begin
              gap_cnt <= gap_cnt + 16'd1;
            end
          end
          P_ADDR: begin
            state <= P_CHK;
          end
          P_CHK: begin
            if (!cfg_done) begin
              gap_cnt <= '0;
              state   <= WAIT;
            end else if (op_rd) begin
              bus.m_addr_o <= REG_RDR;
              state        <= R_ADDR;
            end else begin
              bus.m_write_o <= 1'b1;
              bus.m_be_o    <= 4'hF;
              bus.m_addr_o  <= REG_CFG;
              bus.m_wdata_o <= '0;
              state         <= CLR;
            end
          end
          R_ADDR: begin
            state <= R_CAP;
          end
          R_CAP: begin
            bus.rdata_o   <= bus.m_rdata_i;
            bus.m_write_o <= 1'b1;
            bus.m_be_o    <= 4'hF;
            bus.m_addr_o  <= REG_CFG;
            bus.m_wdata_o <= '0;
            state         <= CLR;
          end
          CLR: begin
            bus.done_o <= bus.gnt_o;
            state      <= DONE;
          end
          DONE: begin
            bus.gnt_o <= '0;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb/tb_i2c_txn_arbiter.sv - self-checking bench for i2c_txn_arbiter with a register-file model of the I2C master
module tb_i2c_txn_arbiter;
  localparam int NREQ        = 4;
  localparam int POLL_GAP    = 3;
  localparam int TIMEOUT_CYC = 100;
  localparam int NEVER       = 32'h7FFF_FFFF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2c_txn_arbiter_if #(.NREQ(NREQ)) bus ();

  i2c_txn_arbiter #(
    .NREQ(NREQ), .POLL_GAP(POLL_GAP), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          owner;
    int          min_gap;
    int          max_gap;
  } wr_t;

  typedef struct {
    int          owner;
    bit          chk_rdata;
    logic [31:0] rdata;
    logic        err;
  } dn_t;

  typedef struct {
    int          idx;
    bit          rd;
    logic [6:0]  dev;
    logic [2:0]  nby;
    logic [31:0] wdata;
    logic [31:0] rdr;
    int          polls;
    logic [31:0] nby_exp;
  } vec_t;

  wr_t exp_wr[$];
  dn_t exp_dn[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // I2C master model: registered reads, CFG reports done a set number of cycles after the start command
  int          cyc       = 0;
  int          start_cyc = 0;
  int          delay_cyc = 0;
  bit          busy      = 1'b0;
  logic [31:0] start_code = 32'h0;
  logic [31:0] rdr_val    = 32'h0;

  function automatic logic [31:0] done_of(input logic [31:0] s);
    if (s == 32'h1) return 32'h3;
    if (s == 32'h4) return 32'hC;
    return s;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.m_write_o && bus.m_addr_o == 5'd16) begin
      if (bus.m_wdata_o != 32'h0) begin
        busy       <= 1'b1;
        start_cyc  <= cyc + 1;
        start_code <= bus.m_wdata_o;
      end else begin
        busy <= 1'b0;
      end
    end
    case (bus.m_addr_o)
      5'd16:   bus.m_rdata_i <= !busy ? 32'h0 :
                                ((cyc - start_cyc >= delay_cyc) ? done_of(start_code) : start_code);
      5'd8:    bus.m_rdata_i <= rdr_val;
      default: bus.m_rdata_i <= 32'h0;
    endcase
  end

  // scoreboard: every bus write and every done pulse is matched against the expected queues
  wr_t w_e;
  dn_t d_e;
  int  gap;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.m_write_o) begin
        if (exp_wr.size() == 0) begin
          check("unexpected_write_addr", {27'd0, bus.m_addr_o}, 32'hFFFF_FFFF);
        end else begin
          w_e = exp_wr.pop_front();
          check("wr_addr", {27'd0, bus.m_addr_o}, {27'd0, w_e.addr});
          check("wr_data", bus.m_wdata_o, w_e.data);
          check("wr_be", {28'd0, bus.m_be_o}, 32'hF);
          check("wr_gnt_owner", {28'd0, bus.gnt_o}, 32'(1 << w_e.owner));
          if (w_e.max_gap > 0) begin
            gap = cyc - start_cyc;
            check("clr_gap_min", {31'd0, gap >= w_e.min_gap}, 32'd1);
            check("clr_gap_max", {31'd0, gap <= w_e.max_gap}, 32'd1);
          end
        end
      end
      if (bus.done_o != '0) begin
        if (exp_dn.size() == 0) begin
          check("unexpected_done", {28'd0, bus.done_o}, 32'h0);
        end else begin
          d_e = exp_dn.pop_front();
          check("done_onehot", {28'd0, bus.done_o}, 32'(1 << d_e.owner));
          check("done_gnt", {28'd0, bus.gnt_o}, 32'(1 << d_e.owner));
          check("done_err", {31'd0, bus.err_o}, {31'd0, d_e.err});
          check("done_be_idle", {28'd0, bus.m_be_o}, 32'h0);
          if (d_e.chk_rdata) check("done_rdata", bus.rdata_o, d_e.rdata);
        end
      end
    end
  end

  task automatic set_ops(input int k, input bit rd, input logic [6:0] dev,
                         input logic [2:0] nby, input logic [31:0] wdata);
    bus.rd_i[k]               = rd;
    bus.dev_addr_i[7*k +: 7]  = dev;
    bus.nby_i[3*k +: 3]       = nby;
    bus.wdata_i[32*k +: 32]   = wdata;
  endtask

  task automatic push_txn(input int idx, input bit rd, input logic [6:0] dev,
                          input logic [31:0] nby_exp, input logic [31:0] wdata,
                          input logic [31:0] rdr, input int dly, input bit to);
    exp_wr.push_back('{5'd0,  nby_exp,        idx, 0, 0});
    exp_wr.push_back('{5'd4,  {25'd0, dev},   idx, 0, 0});
    if (!rd) exp_wr.push_back('{5'd12, wdata, idx, 0, 0});
    exp_wr.push_back('{5'd16, rd ? 32'h4 : 32'h1, idx, 0, 0});
    if (to) exp_wr.push_back('{5'd16, 32'h0, idx, TIMEOUT_CYC - 5, TIMEOUT_CYC + 10});
    else    exp_wr.push_back('{5'd16, 32'h0, idx, dly, 100000});
    exp_dn.push_back('{idx, rd || to, to ? 32'h0 : rdr, to});
  endtask

  task automatic wait_done(input int k, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk);
      #1;
      if (bus.done_o[k]) seen = 1'b1;
    end
    if (seen) bus.req_i[k] = 1'b0;
    check($sformatf("done%0d_seen", k), {31'd0, seen}, 32'd1);
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "gnt"},     {28'd0, bus.gnt_o},  32'h0);
    check({pfx, "done"},    {28'd0, bus.done_o}, 32'h0);
    check({pfx, "err"},     {31'd0, bus.err_o},  32'h0);
    check({pfx, "rdata"},   bus.rdata_o,         32'h0);
    check({pfx, "m_write"}, {31'd0, bus.m_write_o}, 32'h0);
    check({pfx, "m_be"},    {28'd0, bus.m_be_o}, 32'h0);
    check({pfx, "m_addr"},  {27'd0, bus.m_addr_o}, 32'd16);
    check({pfx, "m_wdata"}, bus.m_wdata_o,       32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got expired, expected finish");
    $fatal(1);
  end

  vec_t vecs[5];
  int   rr_order[5];

  initial begin
    vecs[0] = '{0, 1'b0, 7'h50, 3'd2, 32'hA5B6C7D8, 32'h0,        3, 32'd2};
    vecs[1] = '{2, 1'b1, 7'h3C, 3'd4, 32'h0,        32'h11223344, 2, 32'd4};
    vecs[2] = '{1, 1'b0, 7'h11, 3'd0, 32'hDEADBEEF, 32'h0,        1, 32'd1};
    vecs[3] = '{3, 1'b1, 7'h7F, 3'd7, 32'h0,        32'hCAFEF00D, 1, 32'd4};
    vecs[4] = '{3, 1'b0, 7'h01, 3'd5, 32'h13579BDF, 32'h0,        2, 32'd4};
    rr_order = '{0, 1, 2, 3, 0};

    bus.req_i      = '0;
    bus.rd_i       = '0;
    bus.dev_addr_i = '0;
    bus.nby_i      = '0;
    bus.wdata_i    = '0;

    repeat (3) @(posedge clk);
    #1;
    check_reset("reset_");

    // all four requesters pending out of reset: grants 0,1,2,3 then 0 again
    for (int k = 0; k < NREQ; k++) set_ops(k, 1'b0, 7'(32'h20 + k), 3'd1, 32'hC0DE0000 + k);
    delay_cyc = POLL_GAP + 2;
    for (int i = 0; i < 5; i++)
      push_txn(rr_order[i], 1'b0, 7'(32'h20 + rr_order[i]), 32'd1,
               32'hC0DE0000 + rr_order[i], 32'h0, delay_cyc, 1'b0);
    bus.req_i = '1;
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(0, 500);
    @(posedge clk);
    #1;
    bus.req_i[0] = 1'b1;
    wait_done(1, 500);
    wait_done(2, 500);
    wait_done(3, 500);
    wait_done(0, 500);
    repeat (2) @(posedge clk);

    // table-driven single transactions
    for (int v = 0; v < 5; v++) begin
      #1;
      set_ops(vecs[v].idx, vecs[v].rd, vecs[v].dev, vecs[v].nby, vecs[v].wdata);
      rdr_val   = vecs[v].rdr;
      delay_cyc = vecs[v].polls * (POLL_GAP + 2);
      push_txn(vecs[v].idx, vecs[v].rd, vecs[v].dev, vecs[v].nby_exp,
               vecs[v].wdata, vecs[v].rdr, delay_cyc, 1'b0);
      bus.req_i[vecs[v].idx] = 1'b1;
      wait_done(vecs[v].idx, 500);
      repeat (2) @(posedge clk);
    end

    // req1 withdrawn and operands changed after the grant: latched operands still used
    #1;
    set_ops(1, 1'b0, 7'h2A, 3'd3, 32'h12345678);
    delay_cyc = 2 * (POLL_GAP + 2);
    push_txn(1, 1'b0, 7'h2A, 32'd3, 32'h12345678, 32'h0, delay_cyc, 1'b0);
    bus.req_i[1] = 1'b1;
    for (int i = 0; i < 100 && !bus.gnt_o[1]; i++) begin
      @(posedge clk);
      #1;
    end
    check("gnt1_seen", {31'd0, bus.gnt_o[1]}, 32'd1);
    bus.req_i[1] = 1'b0;
    set_ops(1, 1'b1, 7'h55, 3'd6, 32'hFFFF0000);
    wait_done(1, 500);
    repeat (2) @(posedge clk);

    // asynchronous reset while polling; afterwards rr_ptr restarts at 0
    #1;
    set_ops(0, 1'b0, 7'h44, 3'd2, 32'h0BADF00D);
    delay_cyc = NEVER;
    push_txn(0, 1'b0, 7'h44, 32'd2, 32'h0BADF00D, 32'h0, delay_cyc, 1'b0);
    bus.req_i[0] = 1'b1;
    begin
      bit got_start;
      got_start = 1'b0;
      for (int i = 0; i < 100 && !got_start; i++) begin
        @(posedge clk);
        #1;
        if (bus.m_write_o && bus.m_addr_o == 5'd16 && bus.m_wdata_o == 32'h1) got_start = 1'b1;
      end
      check("rst_test_start_seen", {31'd0, got_start}, 32'd1);
    end
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset("async_rst_");
    exp_wr.delete();
    exp_dn.delete();
    set_ops(1, 1'b0, 7'h45, 3'd1, 32'h600DCAFE);
    bus.req_i[1] = 1'b1;
    delay_cyc = POLL_GAP + 2;
    push_txn(0, 1'b0, 7'h44, 32'd2, 32'h0BADF00D, 32'h0, delay_cyc, 1'b0);
    push_txn(1, 1'b0, 7'h45, 32'd1, 32'h600DCAFE, 32'h0, delay_cyc, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(0, 500);
    wait_done(1, 500);
    repeat (2) @(posedge clk);

`ifdef I2C_ARB_TIMEOUT_EN
    // CFG never reports done: watchdog clears CFG and reports err_o
    #1;
    set_ops(2, 1'b0, 7'h66, 3'd3, 32'h77778888);
    delay_cyc = NEVER;
    push_txn(2, 1'b0, 7'h66, 32'd3, 32'h77778888, 32'h0, delay_cyc, 1'b1);
    bus.req_i[2] = 1'b1;
    wait_done(2, 500);
    repeat (2) @(posedge clk);
`endif

    check("exp_wr_drained", exp_wr.size(), 32'd0);
    check("exp_dn_drained", exp_dn.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
